// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   RV32I decode stage that feeds the integer ALU. A fetched instruction and
//   its PC arrive from fetch, rs1/rs2 are read combinationally from the
//   register file, and the decoded ALU bundle is registered towards execute.
//   A single pipeline register with backpressure and flush.
//
// Handshake (both sides):
//   A beat transfers on a rising edge where valid && ready are both high.
//   A producer holds valid and its payload stable until the beat transfers.
//   in_ready = !out_valid || out_ready, so a continuous stream moves one
//   beat per cycle with no bubble.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      fetch offers an instruction
//   in_ready      this stage can accept this cycle
//   in_instr      instruction word
//   in_pc         instruction PC
//   rs1_addr      regfile read address 1 (instr[19:15], combinational)
//   rs2_addr      regfile read address 2 (instr[24:20], combinational)
//   rs1_data      regfile read data 1 (same cycle)
//   rs2_data      regfile read data 2 (same cycle)
//   flush         kill the held and the incoming instruction
//   out_valid     bundle valid for execute
//   out_ready     execute accepts the bundle
//   out_alucode   ALU operation (ALU_* from decode_stage_pkg)
//   out_op1       ALU operand 1
//   out_op2       ALU operand 2
//   out_rd        destination register
//   out_regwrite  write rd at writeback
//   out_illegal   unsupported encoding
//   out_pc        PC of the held instruction, RESET_PC_TAG while idle
// ---------------------------------------------------------------------------

package decode_stage_pkg;

    // ALU operation codes shared with the execute stage.
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_AND  = 4'd10;
    localparam logic [3:0] ALU_JUMP = 4'd11;

endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,

    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alucode,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    // Major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [11:0]     w_imm_i_raw;
    logic [11:0]     w_imm_s_raw;
    logic [31:0]     w_imm_u_raw;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode    = in_instr[6:0];
    assign w_funct3    = in_instr[14:12];
    assign w_funct7    = in_instr[31:25];
    assign w_rd        = in_instr[11:7];
    assign w_imm_i_raw = in_instr[31:20];
    assign w_imm_s_raw = {in_instr[31:25], in_instr[11:7]};
    assign w_imm_u_raw = {in_instr[31:12], 12'b0};

    // Signed casts sign-extend from instr[31] to XLEN.
    assign w_imm_i = XLEN'($signed(w_imm_i_raw));
    assign w_imm_s = XLEN'($signed(w_imm_s_raw));
    assign w_imm_u = XLEN'($signed(w_imm_u_raw));
    // Shift amount is zero-extended: instr[25] belongs to funct7 here.
    assign w_shamt = XLEN'(in_instr[24:20]);

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // ------------------------------------------------------------------
    // funct3 -> ALU op for the funct7=0000000 row of OP / OP-IMM
    // ------------------------------------------------------------------
    logic [3:0] w_f3_alu;

    always_comb begin
        w_f3_alu = ALU_NONE;
        case (w_funct3)
            3'b000:  w_f3_alu = ALU_ADD;
            3'b001:  w_f3_alu = ALU_SLL;
            3'b010:  w_f3_alu = ALU_SLT;
            3'b011:  w_f3_alu = ALU_SLTU;
            3'b100:  w_f3_alu = ALU_XOR;
            3'b101:  w_f3_alu = ALU_SRL;
            3'b110:  w_f3_alu = ALU_OR;
            default: w_f3_alu = ALU_AND;
        endcase
    end

    // ------------------------------------------------------------------
    // Main decode
    // ------------------------------------------------------------------
    logic [3:0]      w_alucode;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_writes_rd;
    logic            w_illegal;
    logic            w_regwrite;

    always_comb begin
        w_alucode   = ALU_NONE;
        w_op1       = '0;
        w_op2       = '0;
        w_writes_rd = 1'b0;
        w_illegal   = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                w_op1       = rs1_data;
                w_op2       = rs2_data;
                w_writes_rd = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    w_alucode = w_f3_alu;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_alucode = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_alucode = ALU_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                w_op1       = rs1_data;
                w_op2       = w_imm_i;
                w_writes_rd = 1'b1;
                case (w_funct3)
                    3'b001: begin
                        w_op2 = w_shamt;
                        if (w_funct7 == F7_BASE) begin
                            w_alucode = ALU_SLL;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        w_op2 = w_shamt;
                        if (w_funct7 == F7_BASE) begin
                            w_alucode = ALU_SRL;
                        end else if (w_funct7 == F7_ALT) begin
                            w_alucode = ALU_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    // No SUBI: funct3=000 is always ADDI whatever funct7 holds.
                    default: w_alucode = w_f3_alu;
                endcase
            end

            OPC_LUI: begin
                w_alucode   = ALU_ADD;
                w_op2       = w_imm_u;
                w_writes_rd = 1'b1;
            end

            OPC_AUIPC: begin
                w_alucode   = ALU_ADD;
                w_op1       = in_pc;
                w_op2       = w_imm_u;
                w_writes_rd = 1'b1;
            end

            // ALU_JUMP produces op2 + 4: the link address.
            OPC_JAL, OPC_JALR: begin
                w_alucode   = ALU_JUMP;
                w_op2       = in_pc;
                w_writes_rd = 1'b1;
            end

            OPC_LOAD: begin
                w_alucode   = ALU_ADD;
                w_op1       = rs1_data;
                w_op2       = w_imm_i;
                w_writes_rd = 1'b1;
            end

            OPC_STORE: begin
                w_alucode = ALU_ADD;
                w_op1     = rs1_data;
                w_op2     = w_imm_s;
            end

            // Branch compare is a subtract; the target is computed elsewhere.
            OPC_BRANCH: begin
                w_alucode = ALU_SUB;
                w_op1     = rs1_data;
                w_op2     = rs2_data;
            end

            // FENCE is a no-op on this in-order core.
            OPC_MISC_MEM: begin
                w_alucode = ALU_NONE;
            end

            default: begin
                w_illegal = 1'b1;
            end
        endcase

        // An illegal encoding carries no operation and no operands.
        if (w_illegal) begin
            w_alucode = ALU_NONE;
            w_op1     = '0;
            w_op2     = '0;
        end
    end

    assign w_regwrite = w_writes_rd && !w_illegal && (w_rd != 5'd0);

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [3:0]      r_alucode;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic            r_illegal;
    logic [XLEN-1:0] r_pc;
    logic            w_accept;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_alucode  <= ALU_NONE;
            r_op1      <= '0;
            r_op2      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_pc       <= RESET_PC_TAG;
        end else if (flush) begin
            // Held beat and any beat accepted this cycle are both dropped.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_alucode  <= w_alucode;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_rd       <= w_rd;
            r_regwrite <= w_regwrite;
            r_illegal  <= w_illegal;
            r_pc       <= in_pc;
        end else if (out_ready) begin
            // Drained with nothing new: payload registers keep their values.
            r_valid <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_alucode  = r_alucode;
    assign out_op1      = r_op1;
    assign out_op2      = r_op2;
    assign out_rd       = r_rd;
    assign out_regwrite = r_regwrite;
    assign out_illegal  = r_illegal;
    assign out_pc       = r_valid ? r_pc : RESET_PC_TAG;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] TAG  = 32'hCAFE0000;
    localparam int          BW   = 107;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alucode;
    logic [31:0] out_op1, out_op2, out_pc;
    logic [4:0]  out_rd;
    logic        out_regwrite, out_illegal;

    // Register file model driven back into the DUT.
    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    decode_stage #(.XLEN(XLEN), .RESET_PC_TAG(TAG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alucode(out_alucode),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    logic [BW-1:0] dut_pack;
    assign dut_pack = {out_alucode, out_op1, out_op2, out_rd, out_regwrite, out_illegal, out_pc};

    // ---------------- scoreboard / counters ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [BW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [BW:0] act, input logic [BW:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] pack(input logic [3:0] a, input logic [31:0] x,
                                           input logic [31:0] y, input logic [4:0] rd,
                                           input logic rw, input logic ill, input logic [31:0] pc);
        return {a, x, y, rd, rw, ill, pc};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Decoded bundle (pc field carries the instruction PC).
    function automatic logic [BW-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        int opc = int'(ins[6:0]);
        int f3  = int'(ins[14:12]);
        int f7  = int'(ins[31:25]);
        int rd  = int'(ins[11:7]);
        logic [31:0] a = regs[ins[19:15]];
        logic [31:0] b = regs[ins[24:20]];
        logic [31:0] imm_i = 32'($signed(ins) >>> 20);
        logic [31:0] imm_s = 32'(($signed(ins) >>> 25) <<< 5) | 32'(ins[11:7]);
        logic [31:0] imm_u = ins & 32'hFFFFF000;
        logic [3:0]  code = ALU_NONE;
        logic [31:0] x = 0, y = 0;
        logic wr = 0, bad = 0;
        case (opc)
            'h33: begin
                x = a; y = b; wr = 1;
                bad = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
                code = f3_op(3'(f3), f7 == 'h20);
            end
            'h13: begin
                x = a; wr = 1;
                if (f3 == 1 || f3 == 5) begin
                    y = 32'(ins[24:20]);
                    bad = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 'h20);
                    code = f3_op(3'(f3), f7 == 'h20);
                end else begin
                    y = imm_i;
                    code = f3_op(3'(f3), 1'b0);
                end
            end
            'h37: begin code = ALU_ADD; y = imm_u; wr = 1; end
            'h17: begin code = ALU_ADD; x = pc; y = imm_u; wr = 1; end
            'h6F, 'h67: begin code = ALU_JUMP; y = pc; wr = 1; end
            'h03: begin code = ALU_ADD; x = a; y = imm_i; wr = 1; end
            'h23: begin code = ALU_ADD; x = a; y = imm_s; end
            'h63: begin code = ALU_SUB; x = a; y = b; end
            'h0F: begin end
            default: bad = 1;
        endcase
        if (bad) begin code = ALU_NONE; x = 0; y = 0; end
        return pack(code, x, y, 5'(rd), wr && !bad && rd != 0, bad, pc);
    endfunction

    // Model of the pipeline register, updated from the stage's transfer rules.
    logic          m_valid = 0;
    logic [BW-1:0] m_bundle = '0;

    function automatic logic [BW:0] model_view();
        logic [BW-1:0] v = m_bundle;
        if (!m_valid) v[31:0] = TAG;
        return {m_valid, v};
    endfunction

    // ---------------- driver ----------------
    task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ordy, input logic rs);
        logic exp_rdy;
        logic [BW-1:0] d;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy; rst = rs;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", {{BW{1'b0}}, in_ready}, {{BW{1'b0}}, exp_rdy});
        chk("rs_addr", {{(BW-9){1'b0}}, rs1_addr, rs2_addr}, {{(BW-9){1'b0}}, ins[19:15], ins[24:20]});
        d = ref_decode(ins, pc);
        // Scoreboard: every beat execute takes must be the oldest pending one.
        if (!rs && out_valid && ordy) begin
            if (exp_q.size() == 0) chk("sb_spurious", {1'b1, dut_pack}, {1'b0, dut_pack});
            else chk("sb_beat", {1'b1, dut_pack}, {1'b1, exp_q.pop_front()});
        end
        @(posedge clk);
        if (rs) begin
            m_valid = 0; m_bundle = pack(ALU_NONE, 0, 0, 0, 0, 0, TAG); exp_q.delete();
        end else if (fl) begin
            m_valid = 0; exp_q.delete();
        end else if (v && exp_rdy) begin
            m_valid = 1; m_bundle = d; exp_q.push_back(d);
        end else if (ordy) begin
            m_valid = 0;
        end
        #1;
        chk("model", {out_valid, dut_pack}, model_view());
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        case ($urandom_range(0, 13))
            0, 1, 2: w[6:0] = 7'h33;
            3, 4, 5: w[6:0] = 7'h13;
            6:  w[6:0] = 7'h37;
            7:  w[6:0] = 7'h17;
            8:  w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h67;
            9:  w[6:0] = 7'h03;
            10: w[6:0] = 7'h23;
            11: w[6:0] = 7'h63;
            12: w[6:0] = 7'h0F;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [BW:0] vec_view(input vec_t t, input logic [31:0] pc);
        return {1'b1, pack(t.alu, t.op1, t.op2, t.rd, t.rw, t.ill, pc)};
    endfunction

    initial begin
        tbl[0]  = '{32'hFFF10093, 32'h0000, ALU_ADD,  32'h5,        32'hFFFFFFFF, 5'd1,  1'b1, 1'b0};
        tbl[1]  = '{32'h40725193, 32'h0004, ALU_SRA,  32'h80000000, 32'h7,        5'd3,  1'b1, 1'b0};
        tbl[2]  = '{32'hFE725193, 32'h0008, ALU_NONE, 32'h0,        32'h0,        5'd3,  1'b0, 1'b1};
        tbl[3]  = '{32'h123452B7, 32'h000C, ALU_ADD,  32'h0,        32'h12345000, 5'd5,  1'b1, 1'b0};
        tbl[4]  = '{32'h000000EF, 32'h0100, ALU_JUMP, 32'h0,        32'h100,      5'd1,  1'b1, 1'b0};
        tbl[5]  = '{32'h00208033, 32'h0104, ALU_ADD,  32'h11111111, 32'h5,        5'd0,  1'b0, 1'b0};
        tbl[6]  = '{32'h402081B3, 32'h0108, ALU_SUB,  32'h11111111, 32'h5,        5'd3,  1'b1, 1'b0};
        tbl[7]  = '{32'hFFFFF397, 32'h2000, ALU_ADD,  32'h2000,     32'hFFFFF000, 5'd7,  1'b1, 1'b0};
        tbl[8]  = '{32'hFE20AE23, 32'h2004, ALU_ADD,  32'h11111111, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0};
        tbl[9]  = '{32'h00208063, 32'h2008, ALU_SUB,  32'h11111111, 32'h5,        5'd0,  1'b0, 1'b0};
        tbl[10] = '{32'h0FF0000F, 32'h200C, ALU_NONE, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0};
        tbl[11] = '{32'h00000073, 32'h2010, ALU_NONE, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
        tbl[12] = '{32'h0080A503, 32'h2014, ALU_ADD,  32'h11111111, 32'h8,        5'd10, 1'b1, 1'b0};
        tbl[13] = '{32'h40109093, 32'h2018, ALU_NONE, 32'h0,        32'h0,        5'd1,  1'b0, 1'b1};
        tbl[14] = '{32'h000100E7, 32'h0040, ALU_JUMP, 32'h0,        32'h40,       5'd1,  1'b1, 1'b0};
        tbl[15] = '{32'h8000C293, 32'h0044, ALU_XOR,  32'h11111111, 32'hFFFFF800, 5'd5,  1'b1, 1'b0};

        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h11111111;
        regs[2] = 32'h5;
        regs[4] = 32'h80000000;

        // Reset state.
        tick(0, 32'h0, 32'h0, 0, 0, 1);
        tick(0, 32'h0, 32'h0, 0, 0, 1);
        chk("reset_state", {out_valid, dut_pack}, {1'b0, pack(ALU_NONE, 0, 0, 0, 0, 0, TAG)});

        // Back-to-back table stream: one valid beat per cycle, in order.
        for (int i = 0; i < 16; i++) begin
            tick(1, tbl[i].instr, tbl[i].pc, 0, 1, 0);
            chk($sformatf("vec%0d", i), {out_valid, dut_pack}, vec_view(tbl[i], tbl[i].pc));
        end

        // Stall for three cycles with a new instruction waiting.
        tick(1, tbl[0].instr, 32'h300, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, tbl[3].instr, 32'h304, 0, 0, 0);
            chk("stall_hold", {out_valid, dut_pack}, vec_view(tbl[0], 32'h300));
        end
        tick(1, tbl[3].instr, 32'h304, 0, 1, 0);
        chk("stall_release", {out_valid, dut_pack}, vec_view(tbl[3], 32'h304));
        tick(0, 32'h0, 32'h0, 0, 1, 0);
        chk("single_beat", {{BW{1'b0}}, out_valid}, {(BW+1){1'b0}});

        // Flush kills an accepted instruction.
        tick(1, tbl[6].instr, 32'h400, 1, 1, 0);
        chk("flush_incoming", {{BW{1'b0}}, out_valid}, {(BW+1){1'b0}});
        // Flush kills a stalled held instruction.
        tick(1, tbl[0].instr, 32'h500, 0, 1, 0);
        tick(0, 32'h0, 32'h0, 1, 0, 0);
        chk("flush_held", {{BW{1'b0}}, out_valid}, {(BW+1){1'b0}});

        // Reset during a stall drops the held instruction.
        tick(1, tbl[0].instr, 32'h600, 0, 1, 0);
        tick(1, tbl[3].instr, 32'h604, 0, 0, 0);
        tick(1, tbl[3].instr, 32'h604, 0, 0, 1);
        chk("reset_in_stall", {out_valid, dut_pack}, {1'b0, pack(ALU_NONE, 0, 0, 0, 0, 0, TAG)});

        // Randomized traffic against the reference model and scoreboard.
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0)
                for (int r = 0; r < 32; r++) regs[r] = $urandom();
            tick($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFFFFFC,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 0);
        end

        // Drain.
        tick(0, 32'h0, 32'h0, 0, 1, 0);
        tick(0, 32'h0, 32'h0, 0, 1, 0);
        chk("drained", {{BW{1'b0}}, out_valid}, {{BW{1'b0}}, exp_q.size() != 0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline decode stage: the producer side of the integer ALU interface.
- Accepts a fetched RV32I instruction and its PC from fetch over a valid/ready handshake and reads rs1/rs2 from the register file.
- Drives a registered ALU bundle to the execute stage: alucode, op1, op2, rd, regwrite and illegal.
- One pipeline register stage, with backpressure and flush.

Parameters:
- XLEN, 32, data and PC width.
- RESET_PC_TAG, 32'h0, value driven on out_pc while out_valid=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rs1_addr  out  5  regfile read address 1, combinational from in_instr[19:15]
- rs2_addr  out  5  regfile read address 2, combinational from in_instr[24:20]
- rs1_data  in  XLEN  regfile read data 1, same cycle
- rs2_data  in  XLEN  regfile read data 2, same cycle
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  bundle valid for execute
- out_ready  in  1  execute accepts bundle
- out_alucode  out  4  ALU operation; shared ALU_* constants from the type package
- out_op1  out  XLEN  ALU operand 1
- out_op2  out  XLEN  ALU operand 2
- out_rd  out  5  destination register
- out_regwrite  out  1  write rd at writeback
- out_illegal  out  1  unsupported encoding
- out_pc  out  XLEN  PC of the held instruction

Behaviour:
- Reset, synchronous and active-high:
  - out_valid=0, out_alucode=ALU_NONE.
  - out_op1, out_op2 = 0; out_rd=0; out_regwrite=0; out_illegal=0; out_pc=RESET_PC_TAG.
  - Reset overrides flush and the handshake. Reset asserted mid-stall drops the held instruction.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
  - Capture on in_valid && in_ready: all out_* load next edge, out_valid=1.
  - If out_ready && !in_valid: out_valid->0; data outputs hold their last values.
  - If out_valid && !out_ready: all out_* hold stable.
  - Latency: 1 cycle from accept to out_valid.
- Flush:
  - On flush=1, next edge out_valid=0 and the incoming instruction is discarded, even if in_valid && in_ready.
  - in_ready stays per the formula; the accepted beat is simply dropped.
- Decode by opcode [6:0]:
  - OP (0110011): op1=rs1_data, op2=rs2_data.
    - funct7=0000000 with funct3 0..7 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - funct7=0100000 with funct3 000 -> SUB; with funct3 101 -> SRA.
    - Any other combination -> illegal.
  - OP-IMM (0010011): op1=rs1_data, op2=sign-extended I-imm.
    - funct3 map as OP.
    - SLLI requires funct7=0000000. SRLI/SRAI select on funct7=0000000 / 0100000; other funct7 -> illegal.
    - For shifts, op2 = {27'b0, instr[24:20]}.
  - LUI: ALU_ADD, op1=0, op2={instr[31:12],12'b0}.
  - AUIPC: ALU_ADD, op1=in_pc, op2=U-imm.
  - JAL, JALR: ALU_JUMP, op1=0, op2=in_pc, so the ALU yields the link address pc+4.
  - LOAD: ALU_ADD, op1=rs1_data, op2=I-imm; regwrite=1.
  - STORE: ALU_ADD, op1=rs1_data, op2=S-imm; regwrite=0.
  - BRANCH: ALU_SUB, op1=rs1_data, op2=rs2_data; regwrite=0.
  - MISC-MEM (FENCE): ALU_NONE, regwrite=0, illegal=0.
  - Any other opcode, including SYSTEM: ALU_NONE, op1=op2=0, regwrite=0, illegal=1.
- regwrite is forced 0 when rd=x0 or illegal=1. out_rd = instr[11:7] for all encodings.
- Immediates are always sign-extended from instr[31]. All arithmetic is XLEN wide; no truncation warnings permitted.

Test Plan:
- Reset then ADDI x1,x2,-1 (0xFFF10093), rs1_data=5, out_ready=1 -> next cycle out_valid=1, ALU_ADD, op1=5, op2=0xFFFFFFFF, rd=1, regwrite=1.
- SRAI x3,x4,7 (0x40725193), rs1_data=0x80000000 -> ALU_SRA, op2=7. Then same word with funct7=0x7F -> illegal=1, ALU_NONE, regwrite=0.
- LUI x5,0x12345 (0x123452B7) -> op1=0, op2=0x12345000, ALU_ADD. JAL x1 at pc=0x100 -> ALU_JUMP, op2=0x100, rd=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 and a new instr -> in_ready=0, outputs unchanged. Release -> new instruction appears next cycle, no beat lost or duplicated.
- flush=1 in the same cycle as an accepted ADD -> out_valid=0 next cycle. A back-to-back stream of 4 instrs with out_ready=1 -> 4 consecutive valid beats, in order.
- ADD x0,x1,x2 -> regwrite=0. rst asserted during a stall -> out_valid=0 and out_pc=RESET_PC_TAG next cycle.
